// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, stall, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, stall, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one access at a time, stalls the pipeline until the
// response, and commits stores / captures load data on the edge that enters the response state.
module dmem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rdata_q;
  logic [15:0]         mem_q [0:(1<<ADDR_W)-1];
  logic                commit_s;

  // The access completes on the edge where WAIT sees an expired counter.
  assign commit_s = (state_q == WAIT) && (cnt_q == 4'd0);

  // Next-state, countdown and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 2);
          wr_d    = bus.req_write;
          idx_d   = bus.req_addr[ADDR_W:1];
          wdata_d = bus.req_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture and load-data registers; reset aborts any pending access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (commit_s && !wr_q) begin
        rdata_q <= mem_q[idx_q];
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  // Backing store keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (commit_s && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.stall     = bus.req_valid & ~bus.rsp_valid;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that sits on the far side of the pipeline's MEM-stage memory port. It accepts one load or store request at a time from the MEM stage, models a fixed-latency main memory with a countdown state machine, and drives a stall back to the pipeline until the access completes. It holds the word-addressed backing store, and writes commit only when the response is issued.

## Interface
Parameters:
- LATENCY, 4, cycles from request acceptance to response; legal range 2..15.
- ADDR_W, 10, word-index width; backing store depth is 2^ADDR_W 16-bit words.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  MEM stage has a memory op (load or store) this cycle.
- req_write  in  1  1 = store, 0 = load; sampled only at acceptance.
- req_addr  in  16  byte address; word index = req_addr[ADDR_W:1]; bit 0 and bits above ADDR_W ignored.
- req_wdata  in  16  store data; sampled only at acceptance.
- req_ready  out  1  responder idle, request will be accepted this edge.
- stall  out  1  pipeline must hold IF..MEM this cycle.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  16  load data; valid while rsp_valid is high for a load.

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- Acceptance: edge where state == IDLE and req_valid == 1. Captures req_write, word index, req_wdata into internal registers; loads 4-bit counter with LATENCY-2; next state WAIT.
- WAIT: counter decrements each edge; when counter == 0 at an edge, next state RESP. Inputs are ignored in WAIT, including req_valid dropping or address/data changing.
- Entering RESP (the edge leaving WAIT):
  - store: mem[idx] <= captured wdata.
  - load: rsp_rdata <= mem[idx].
- RESP: rsp_valid = 1 for exactly one cycle; next state IDLE unconditionally. No acceptance occurs in RESP.
- rsp_rdata holds its last load value through stores and idle cycles.
- Outputs:
  - req_ready = (state == IDLE).
  - rsp_valid = (state == RESP).
  - stall = req_valid & ~rsp_valid (combinational), so the pipeline advances on the same edge the response is issued.
- Backing store is not cleared by reset. Contents are undefined until written, except through an optional $readmemh init file used by the bench.
- Address wrap: word indices alias modulo 2^ADDR_W. No error flag.

## Timing
- Request present in IDLE in cycle t (accepted at end of t): WAIT spans cycles t+1 .. t+LATENCY-1, RESP is cycle t+LATENCY.
- Total stall for one access is LATENCY cycles (t .. t+LATENCY-1). Stall is low in cycle t+LATENCY.
- Back-to-back requests: earliest next acceptance is cycle t+LATENCY+1, giving one access per LATENCY+1 cycles.
- Read-after-write to the same word: the store commits entering RESP, so any later load returns the new data.
- Reset values (asynchronous, while rst_n low):
  - state IDLE, counter 0.
  - req_ready 1, rsp_valid 0, rsp_rdata 16'h0000.
  - captured registers 0.
  - stall follows req_valid.
- Reset mid-operation: the pending access is aborted with no memory write and no rsp_valid. After rst_n rises, the next edge with req_valid accepts a fresh request.
- req_valid low in IDLE: no state change and stall is 0.

## Test plan
- Load, LATENCY=4: preload mem[5]=16'hBEEF; req_valid=1, req_write=0, req_addr=16'h000A in cycle 0. Expect stall high in cycles 0-3, rsp_valid high in cycle 4 only, rsp_rdata=16'hBEEF, req_ready low in cycles 1-4.
- Store then load: store 16'h1234 to addr 16'h0020, then load addr 16'h0021. Expect the load to return 16'h1234 (bit 0 ignored) and rsp_rdata to be unchanged during the store response.
- Back-to-back: hold req_valid high across three loads. Expect rsp_valid pulses exactly 5 cycles apart, and stall low only on the pulse cycles.
- Input change during WAIT: accept a store to addr 16'h0004 with data 16'hAAAA, then change req_addr and req_wdata in cycle 2. Expect mem[2]=16'hAAAA and the new address untouched.
- Reset mid-op: accept a store of 16'h5555 to mem[3] (previously 16'h0001), then pulse rst_n low in cycle 2. Expect no rsp_valid, mem[3] still 16'h0001, req_ready=1 and rsp_rdata=0 immediately at reset assertion.
- Wrap and minimum latency: LATENCY=2, ADDR_W=10; store to addr 16'h0802, then load 16'h0002. Expect the same word (index 1) read back, rsp_valid in cycle t+2, and a total stall of 2 cycles.
